// File: rtl/controlador_tx_pkg.sv
// paquete_8b10b: shared constants for the frame transmitter.
// Holds the 8b/10b control characters used as frame delimiters and fill,
// plus the transmitter FSM state encoding and its frame-close reasons.
package paquete_8b10b;

  localparam logic [7:0] K28_5 = 8'hBC;  // idle / comma fill
  localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
  localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
  localparam logic [7:0] K30_7 = 8'hFE;  // frame abort

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SOF    = 3'd1,
    DATOS  = 3'd2,
    EOF    = 3'd3,
    ABORTO = 3'd4
  } estado_t;

  // Why the frame is closing once the last byte is already on the wire
  typedef enum logic [1:0] {
    CIERRE_NO     = 2'd0,
    CIERRE_EOF    = 2'd1,
    CIERRE_ABORTO = 2'd2
  } cierre_t;

endpackage

// File: rtl/controlador_tx_if.sv
// controlador_tx_if: two-requester byte handshake into the transmitter.
//   reqN    requester N has a byte      datosN  byte, stable while reqN
//   ultimoN byte is last of frame       listoN  byte accepted (req & listo)
// master = requester side, slave = transmitter side.
interface controlador_tx_if;
  logic       req0, req1;
  logic [7:0] datos0, datos1;
  logic       ultimo0, ultimo1;
  logic       listo0, listo1;

  modport master (output req0, req1, datos0, datos1, ultimo0, ultimo1,
                  input  listo0, listo1);
  modport slave  (input  req0, req1, datos0, datos1, ultimo0, ultimo1,
                  output listo0, listo1);
endinterface

// File: rtl/controlador_tx_arbitro_rr.sv
// arbitro_rr: two-way round-robin arbiter with its own priority register.
//   clk, rst  clock / synchronous active-high reset
//   req0/1    pending requests
//   tomar     latch the current winner into concedido
//   liberar   frame finished: priority moves to the requester not served
//   concedido latched grant (0 = requester 0, 1 = requester 1)
module arbitro_rr (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic tomar,
  input  logic liberar,
  output logic concedido
);
  logic prioridad;  // 0 favours requester 0
  logic eleccion;

  always_comb begin
    eleccion = prioridad;
    if (!prioridad && !req0 && req1) eleccion = 1'b1;
    if ( prioridad && !req1 && req0) eleccion = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prioridad <= 1'b0;
      concedido <= 1'b0;
    end else begin
      if (tomar)   concedido <= eleccion;
      if (liberar) prioridad <= ~concedido;
    end
  end
endmodule

// File: rtl/controlador_tx.sv
// controlador_tx: frames bytes from two requesters into an 8b/10b encoder.
//   clk, rst    clock / synchronous active-high reset
//   bus         controlador_tx_if.slave (req/datos/ultimo in, listo out)
//   entradas, K byte and control flag to the encoder (registered)
//   enb         encoder enable, high from the first edge after reset
//   ocupado     high from the FB cycle through the FD/FE cycle
// Optional: `define COMA_PERIODICA_EN inserts a K28.5 slot after every
// PERIODO_COMA consecutive data bytes.
//
// Output stream: BC.. FB d1 .. dn FD (or FE) BC..  A byte accepted on an
// edge is shown the next cycle, so acceptance already runs in the FB cycle
// and the cycle showing the final byte closes the frame (cierre) without
// accepting. A comma slot is the cycle whose edge loads BC: listo is low
// there and the byte after the comma is accepted while BC is shown.
module controlador_tx
  import paquete_8b10b::*;
#(
  parameter int PERIODO_COMA = 32,
  parameter int MAX_LONG     = 64
) (
  input  logic            clk,
  input  logic            rst,
  controlador_tx_if.slave bus,
  output logic [7:0]      entradas,
  output logic            K,
  output logic            enb,
  output logic            ocupado
);
  localparam int CW = $clog2(MAX_LONG + 1);

  estado_t       estado;
  cierre_t       cierre;
  logic [CW-1:0] cnt;
  logic          concedido;
  logic          req_g, ult_g;
  logic [7:0]    dato_g;
  logic          en_trama, coma_ahora, listo_act;

  arbitro_rr u_arb (
    .clk       (clk),
    .rst       (rst),
    .req0      (bus.req0),
    .req1      (bus.req1),
    .tomar     (estado == IDLE),
    .liberar   (estado == EOF || estado == ABORTO),
    .concedido (concedido)
  );

  assign req_g  = concedido ? bus.req1    : bus.req0;
  assign ult_g  = concedido ? bus.ultimo1 : bus.ultimo0;
  assign dato_g = concedido ? bus.datos1  : bus.datos0;

  assign en_trama  = (estado == SOF || estado == DATOS) && (cierre == CIERRE_NO);
  assign listo_act = en_trama && !coma_ahora;
  assign bus.listo0 = listo_act && !concedido;
  assign bus.listo1 = listo_act &&  concedido;

`ifdef COMA_PERIODICA_EN
  localparam int PW = $clog2(PERIODO_COMA + 1);
  logic [PW-1:0] ncoma;  // consecutive data bytes since SOF or last comma

  assign coma_ahora = en_trama && (ncoma == PW'(PERIODO_COMA));

  always_ff @(posedge clk) begin
    if (rst || estado == IDLE) ncoma <= '0;
    else if (coma_ahora)       ncoma <= '0;
    else if (listo_act && req_g) ncoma <= ncoma + 1'b1;
  end
`else
  assign coma_ahora = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= IDLE;
      cierre   <= CIERRE_NO;
      cnt      <= '0;
      entradas <= K28_5;
      K        <= 1'b1;
      enb      <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      enb <= 1'b1;
      case (estado)
        IDLE: begin
          entradas <= K28_5;
          K        <= 1'b1;
          if (bus.req0 || bus.req1) begin
            estado   <= SOF;
            entradas <= K27_7;
            cnt      <= '0;
            cierre   <= CIERRE_NO;
            ocupado  <= 1'b1;
          end
        end
        SOF, DATOS: begin
          if (cierre == CIERRE_EOF) begin
            estado   <= EOF;
            entradas <= K29_7;
            K        <= 1'b1;
          end else if (cierre == CIERRE_ABORTO) begin
            estado   <= ABORTO;
            entradas <= K30_7;
            K        <= 1'b1;
          end else if (coma_ahora) begin
            estado   <= DATOS;
            entradas <= K28_5;
            K        <= 1'b1;
          end else if (!req_g) begin
            // requester withdrew mid-frame
            estado   <= ABORTO;
            entradas <= K30_7;
            K        <= 1'b1;
          end else begin
            estado   <= DATOS;
            entradas <= dato_g;
            K        <= 1'b0;
            cnt      <= cnt + 1'b1;
            // ultimo wins over the length limit on the same byte
            if (ult_g)                          cierre <= CIERRE_EOF;
            else if (cnt == CW'(MAX_LONG - 1))  cierre <= CIERRE_ABORTO;
          end
        end
        EOF, ABORTO: begin
          estado   <= IDLE;
          entradas <= K28_5;
          K        <= 1'b1;
          ocupado  <= 1'b0;
        end
        default: begin
          estado   <= IDLE;
          entradas <= K28_5;
          K        <= 1'b1;
          ocupado  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_controlador_tx.sv
// Directed bench for controlador_tx. dut: MAX_LONG=4; dut2: MAX_LONG=64,
// PERIODO_COMA=3 (comma stream when COMA_PERIODICA_EN is defined).
// Outputs are sampled on the falling edge; a requester presents bytes in
// order and advances whenever req && listo was high at that falling edge.
module tb_controlador_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  controlador_tx_if a();
  controlador_tx_if b();

  logic [7:0] ent_a, ent_b;
  logic       k_a, k_b, enb_a, enb_b, ocu_a, ocu_b;

  controlador_tx #(.PERIODO_COMA(3), .MAX_LONG(4)) dut (
    .clk(clk), .rst(rst), .bus(a),
    .entradas(ent_a), .K(k_a), .enb(enb_a), .ocupado(ocu_a));

  controlador_tx #(.PERIODO_COMA(3), .MAX_LONG(64)) dut2 (
    .clk(clk), .rst(rst), .bus(b),
    .entradas(ent_b), .K(k_b), .enb(enb_b), .ocupado(ocu_b));

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] tx0 [16];
  logic [7:0] tx1 [16];
  int         n0, corte0, n1, corte1;
  logic [8:0] esp [32];   // {K, entradas} expected per cycle
  int         nesp;
  logic [8:0] obs [32];
  logic       l0 [32];
  logic       l1 [32];
  logic       ocu [32];

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic prep(input int a0, input int k0, input int a1, input int k1);
    n0 = a0; corte0 = k0; n1 = a1; corte1 = k1; nesp = 0;
  endtask

  task automatic ex(input logic [8:0] v);
    esp[nesp] = v;
    nesp++;
  endtask

  // Run 'ciclos' falling edges against dut (sel=0) or dut2 (sel=1)
  task automatic correr(input string tag, input bit sel, input int ciclos);
    int i0 = 0;
    int i1 = 0;
    bit r0, r1;
    for (int c = 0; c < ciclos; c++) begin
      @(negedge clk);
      if (sel) begin
        obs[c] = {k_b, ent_b}; ocu[c] = ocu_b; l0[c] = b.listo0; l1[c] = b.listo1;
      end else begin
        obs[c] = {k_a, ent_a}; ocu[c] = ocu_a; l0[c] = a.listo0; l1[c] = a.listo1;
      end
      if (c < nesp) chk($sformatf("%s_sal%0d", tag, c), 16'(obs[c]), 16'(esp[c]));
      r0 = (i0 < corte0);
      r1 = (i1 < corte1);
      if (sel) begin
        b.req0 = r0; b.datos0 = tx0[i0]; b.ultimo0 = (i0 == n0 - 1);
        b.req1 = r1; b.datos1 = tx1[i1]; b.ultimo1 = (i1 == n1 - 1);
      end else begin
        a.req0 = r0; a.datos0 = tx0[i0]; a.ultimo0 = (i0 == n0 - 1);
        a.req1 = r1; a.datos1 = tx1[i1]; a.ultimo1 = (i1 == n1 - 1);
      end
      if (r0 && l0[c]) i0++;
      if (r1 && l1[c]) i1++;
    end
  endtask

  initial begin
    a.req0 = 0; a.req1 = 0; a.datos0 = 0; a.datos1 = 0; a.ultimo0 = 0; a.ultimo1 = 0;
    b.req0 = 0; b.req1 = 0; b.datos0 = 0; b.datos1 = 0; b.ultimo0 = 0; b.ultimo1 = 0;

    // Reset held two cycles, then released
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ent",   16'(ent_a), 16'h00BC);
    chk("rst_k",     16'(k_a), 16'h1);
    chk("rst_enb",   16'(enb_a), 16'h0);
    chk("rst_ocu",   16'(ocu_a), 16'h0);
    chk("rst_listo", 16'({a.listo0, a.listo1}), 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_enb", 16'(enb_a), 16'h1);
    chk("rel_ent", 16'({k_a, ent_a}), 16'h01BC);

    // Reset in the middle of a frame: no FD/FE afterwards
    a.req0 = 1'b1; a.datos0 = 8'h5A; a.ultimo0 = 1'b0;
    @(negedge clk);
    chk("mid_sof", 16'({k_a, ent_a}), 16'h01FB);
    @(negedge clk);
    chk("mid_dato", 16'({k_a, ent_a}), 16'h005A);
    rst = 1'b1; a.req0 = 1'b0;
    @(negedge clk);
    chk("mid_rst_ent", 16'({k_a, ent_a}), 16'h01BC);
    chk("mid_rst_ocu", 16'(ocu_a), 16'h0);
    chk("mid_rst_enb", 16'(enb_a), 16'h0);
    chk("mid_rst_listo", 16'(a.listo0), 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_post_ent", 16'({k_a, ent_a}), 16'h01BC);
    chk("mid_post_enb", 16'(enb_a), 16'h1);

    // Arbitration from reset: both request together, 0 then 1
    prep(1, 1, 1, 1);
    tx0[0] = 8'hA0; tx1[0] = 8'hB1;
    ex(9'h1BC); ex(9'h1FB); ex(9'h0A0); ex(9'h1FD);
    ex(9'h1BC); ex(9'h1FB); ex(9'h0B1); ex(9'h1FD); ex(9'h1BC);
    correr("arb", 1'b0, 10);
    chk("arb_listo1_f0", 16'({l1[0], l1[1], l1[2], l1[3]}), 16'h0);
    chk("arb_listo0_sof", 16'(l0[1]), 16'h1);
    chk("arb_listo1_sof", 16'(l1[5]), 16'h1);
    chk("arb_listo0_f1", 16'(l0[5]), 16'h0);

    // Basic three-byte frame
    prep(3, 3, 0, 0);
    tx0[0] = 8'h01; tx0[1] = 8'h02; tx0[2] = 8'h03;
    ex(9'h1BC); ex(9'h1FB); ex(9'h001); ex(9'h002); ex(9'h003); ex(9'h1FD); ex(9'h1BC);
    correr("basico", 1'b0, 8);
    chk("basico_ocu_idle", 16'(ocu[0]), 16'h0);
    chk("basico_ocu_sof",  16'(ocu[1]), 16'h1);
    chk("basico_ocu_eof",  16'(ocu[5]), 16'h1);
    chk("basico_ocu_fin",  16'(ocu[6]), 16'h0);

    // Abort: requester drops after two of five bytes
    prep(5, 2, 0, 0);
    tx0[0] = 8'h11; tx0[1] = 8'h22; tx0[2] = 8'h33; tx0[3] = 8'h44; tx0[4] = 8'h55;
    ex(9'h1BC); ex(9'h1FB); ex(9'h011); ex(9'h022); ex(9'h1FE); ex(9'h1BC);
    correr("aborto", 1'b0, 7);
    chk("aborto_ocu_fe",  16'(ocu[4]), 16'h1);
    chk("aborto_ocu_fin", 16'(ocu[5]), 16'h0);

    // Length limit 4 with a six-byte stream: FE, then a fresh frame
    prep(6, 6, 0, 0);
    for (int i = 0; i < 6; i++) tx0[i] = 8'h21 + 8'(i);
    ex(9'h1BC); ex(9'h1FB); ex(9'h021); ex(9'h022); ex(9'h023); ex(9'h024); ex(9'h1FE);
    ex(9'h1BC); ex(9'h1FB); ex(9'h025); ex(9'h026); ex(9'h1FD); ex(9'h1BC);
    correr("limite", 1'b0, 14);
    chk("limite_listo_tras4", 16'(l0[5]), 16'h0);

    // Fourth byte carries ultimo: EOF, not abort
    prep(4, 4, 0, 0);
    for (int i = 0; i < 4; i++) tx0[i] = 8'h31 + 8'(i);
    ex(9'h1BC); ex(9'h1FB); ex(9'h031); ex(9'h032); ex(9'h033); ex(9'h034); ex(9'h1FD); ex(9'h1BC);
    correr("ult_max", 1'b0, 9);

    // Seven-byte frame on dut2 (PERIODO_COMA=3)
    prep(7, 7, 0, 0);
    for (int i = 0; i < 7; i++) tx0[i] = 8'h41 + 8'(i);
`ifdef COMA_PERIODICA_EN
    ex(9'h1BC); ex(9'h1FB); ex(9'h041); ex(9'h042); ex(9'h043); ex(9'h1BC); ex(9'h044);
    ex(9'h045); ex(9'h046); ex(9'h1BC); ex(9'h047); ex(9'h1FD); ex(9'h1BC);
    correr("coma", 1'b1, 14);
    chk("coma_listo_slot1", 16'(l0[4]), 16'h0);
    chk("coma_listo_slot2", 16'(l0[8]), 16'h0);
    chk("coma_listo_tras",  16'(l0[5]), 16'h1);
`else
    ex(9'h1BC); ex(9'h1FB); ex(9'h041); ex(9'h042); ex(9'h043); ex(9'h044);
    ex(9'h045); ex(9'h046); ex(9'h047); ex(9'h1FD); ex(9'h1BC);
    correr("sin_coma", 1'b1, 12);
    chk("sin_coma_listo", 16'(l0[4]), 16'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/controlador_tx.md
CONTROLADOR_TX -- requirements
Module: controlador_tx

Interface
REQ-001 SHALL have parameter PERIODO_COMA, default 32, which sets the number of consecutive data bytes between forced comma insertions (used only with COMA_PERIODICA_EN).
REQ-002 SHALL have parameter MAX_LONG, default 64, which sets the maximum number of data bytes per frame.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports req0/req1  input  1  requester N has a valid byte.
REQ-006 SHALL have ports datos0/datos1  input  8  requester N byte, held stable while reqN is high.
REQ-007 SHALL have ports ultimo0/ultimo1  input  1  the presented byte is the last byte of the frame.
REQ-008 SHALL have ports listo0/listo1  output  1  byte accepted; the transfer occurs on an edge where reqN and listoN are both high.
REQ-009 SHALL have port entradas  output  8  byte to the 8b/10b encoder.
REQ-010 SHALL have port K  output  1  control-character flag to the encoder.
REQ-011 SHALL have port enb  output  1  encoder enable.
REQ-012 SHALL have port ocupado  output  1  high while a frame is in progress (SOF through EOF/abort).

Function
REQ-013 SHALL implement FSM states IDLE, SOF, DATOS, EOF, ABORTO, with registered outputs loaded on the edge that enters each state or slot.
REQ-014 SHALL in IDLE drive entradas=8'hBC (K28.5) with K=1 every cycle and hold listo0/listo1 low.
REQ-015 SHALL grant a requester in IDLE when any reqN is high: grant goes to the highest-priority requester, and the next state is SOF.
REQ-016 SHALL in SOF drive 8'hFB (K27.7) with K=1 for exactly one cycle, then go to DATOS.
REQ-017 SHALL in DATOS assert listoN combinationally only for the granted N, and not during a comma slot.
REQ-018 SHALL, on each accepted byte, present it on entradas with K=0 on the next cycle (latency 1).
REQ-019 SHALL go to EOF on acceptance of a byte with ultimoN=1, then drive 8'hFD (K29.7) with K=1 for one cycle, then return to IDLE.
REQ-020 SHALL treat the granted reqN low in DATOS (outside a comma slot) as an abort: next state ABORTO, which drives 8'hFE (K30.7) with K=1 for one cycle, then goes to IDLE.
REQ-021 SHALL, when accepting the MAX_LONG-th byte with ultimo=0, accept that byte and then go to ABORTO.
REQ-022 SHALL, on acceptance of an ultimo byte, go to EOF and not ABORTO, even when that byte is the MAX_LONG-th.
REQ-023 SHALL use round-robin priority: after each EOF or ABORTO, priority passes to the requester not just served; prioridad=0 favours requester 0.
REQ-024 SHALL keep the non-granted requester's listo low for the entire frame.
REQ-025 SHALL keep the byte counter wide enough for MAX_LONG, reset it on SOF, and never let it wrap within a frame.
REQ-026 SHALL assert ocupado from the SOF output cycle through the EOF/FE output cycle inclusive.

Reset
REQ-027 SHALL, when rst=1 at a posedge, force state=IDLE, entradas=8'hBC, K=1, enb=0, listo0=listo1=0, ocupado=0, prioridad=0, and clear all counters.
REQ-028 SHALL raise enb on the first edge after rst falls; enb then stays high.
REQ-029 SHALL, on reset during a frame, abandon the frame immediately with no EOF/FE emitted.

Configuration
REQ-030 SHALL, with COMA_PERIODICA_EN defined, after PERIODO_COMA consecutive accepted data bytes in DATOS, insert one slot with entradas=8'hBC, K=1, listo low and no abort check, then resume; the consecutive count resets at that slot and at SOF.
REQ-031 SHALL, without COMA_PERIODICA_EN, never insert commas inside a frame, and PERIODO_COMA SHALL be unused.

Structure
REQ-032 SHALL place constants K28_5=8'hBC, K27_7=8'hFB, K29_7=8'hFD, K30_7=8'hFE and the FSM state encoding in shared package paquete_8b10b.
REQ-033 SHALL use one sub-module, arbitro_rr (two-way round-robin grant plus priority register), instantiated once.

Verification
REQ-034 SHALL test reset: rst=1 for 2 cycles -> entradas=BC, K=1, enb=0; one cycle after release -> enb=1.
REQ-035 SHALL test a basic frame: req0 with bytes 01,02,03 (ultimo on 03), req held -> output sequence BC, FB, 01, 02, 03, FD, BC with K=1,1,0,0,0,1,1.
REQ-036 SHALL test arbitration: req0 and req1 rise together from reset, each sending a one-byte frame -> requester 0 served first, then requester 1; listo1 low throughout frame 0.
REQ-037 SHALL test abort: req0 drops after byte 2 of 5 -> output FB, b1, b2, FE (K=1), then BC; ocupado falls after FE.
REQ-038 SHALL test length limit: MAX_LONG=4 with a 6-byte stream -> 4 bytes accepted, then FE; next frame starts with fresh count.
REQ-039 SHALL test comma insertion: with COMA_PERIODICA_EN and PERIODO_COMA=3, a 7-byte frame -> d1 d2 d3 BC d4 d5 d6 BC d7 FD, with listo low during each BC slot.
